// File: rtl/count_ctrl_pkg.sv
// Shared types and default sizes for the count controller and its prescaler.
package count_ctrl_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_PRESC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_ctrl_if.sv
// Bundle between the controller, its requester and the external loadable counter.
interface count_ctrl_if
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
);
    logic               start;
    logic               stop;
    logic               auto_reload;
    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   end_val;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   count;
    logic               load;
    logic               enable;
    logic [WIDTH-1:0]   data_out;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, auto_reload, start_val, end_val, presc, count,
        input  load, enable, data_out, busy, done
    );

    modport slave (
        input  start, stop, auto_reload, start_val, end_val, presc, count,
        output load, enable, data_out, busy, done
    );
endinterface

// File: rtl/count_ctrl_tick_gen.sv
// Prescaler: free-runs while enabled and emits a tick every period+1 cycles.
module tick_gen
    import count_ctrl_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] period,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/count_ctrl.sv
// Run sequencer for an external loadable counter: load, tick-paced enables, done pulse.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic       clk,
    input  logic       rst_n,
    count_ctrl_if.slave bus
);
    state_t             state_reg;
    logic [WIDTH-1:0]   start_val_reg;
    logic [WIDTH-1:0]   end_val_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic               auto_reload_reg;
    logic               tick;
    logic               at_end;

    tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_reg != RUN),
        .en     (state_reg == RUN),
        .period (presc_reg),
        .tick   (tick)
    );

    // The counter's own output closes the loop, so terminal detection sees the live count.
    assign at_end = (bus.count == end_val_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            start_val_reg   <= '0;
            end_val_reg     <= '0;
            presc_reg       <= '0;
            auto_reload_reg <= 1'b0;
        end else if (bus.stop) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        start_val_reg   <= bus.start_val;
                        end_val_reg     <= bus.end_val;
                        presc_reg       <= bus.presc;
                        auto_reload_reg <= bus.auto_reload;
                        state_reg       <= LOAD;
                    end
                end
                LOAD:    state_reg <= RUN;
                RUN:     if (tick && at_end) state_reg <= DONE;
                DONE:    state_reg <= auto_reload_reg ? LOAD : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.load     = (state_reg == LOAD);
    assign bus.enable   = (state_reg == RUN) && tick && !at_end;
    assign bus.done     = (state_reg == DONE);
    assign bus.busy     = (state_reg != IDLE);
    assign bus.data_out = start_val_reg;
endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: a loadable counter closes the loop, runs are checked against timing formulas.
module tb_count_ctrl;
    localparam int W  = 4;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    count_ctrl_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

    count_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream loadable counter
    logic [W-1:0] cnt_model;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt_model <= '0;
        else if (bus.load)   cnt_model <= bus.data_out;
        else if (bus.enable) cnt_model <= cnt_model + 1'b1;
    end
    assign bus.count = cnt_model;

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] obs();
        return {bus.load, bus.enable, bus.done, bus.busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_start(input int sv, input int ev, input int p, input bit ar);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.stop        = 1'b0;
        bus.auto_reload = ar;
        bus.start_val   = sv[W-1:0];
        bus.end_val     = ev[W-1:0];
        bus.presc       = p[PW-1:0];
    endtask

    // One non-reloading run; per-cycle expectations come from the latency rule.
    task automatic run_obs(input int sv, input int ev, input int p, input bit wiggle,
                           output int n_en, output int done_cyc);
        int n, per, dcyc, k;
        logic [3:0] exp;
        n    = (ev - sv) & ((1 << W) - 1);
        per  = p + 1;
        dcyc = 2 + (n + 1) * per;
        n_en = 0;
        done_cyc = -1;
        drive_start(sv, ev, p, 1'b0);
        for (int c = 1; c <= dcyc + 1; c++) begin
            @(negedge clk);
            if (c == 1)         exp = 4'b1001;
            else if (c < dcyc) begin
                k   = (c - 2) / per;
                exp = {1'b0, (((c - 2) % per) == p) && (k < n), 1'b0, 1'b1};
            end
            else if (c == dcyc) exp = 4'b0011;
            else                exp = 4'b0000;
            check($sformatf("run %0d->%0d p%0d c%0d", sv, ev, p, c), obs(), exp);
            if (c == 1) check($sformatf("data_out %0d", sv), bus.data_out, sv[W-1:0]);
            if (bus.enable) n_en++;
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (wiggle && c <= dcyc) begin
                bus.start       = $urandom_range(0, 1);
                bus.auto_reload = $urandom_range(0, 1);
                bus.start_val   = W'($urandom);
                bus.end_val     = W'($urandom);
                bus.presc       = PW'($urandom);
            end else begin
                bus.start       = 1'b0;
                bus.auto_reload = 1'b0;
            end
        end
    endtask

    typedef struct {
        int sv;
        int ev;
        int p;
        int n_en;
        int done_cyc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n_en, dc, sv, ev, p;
        logic [3:0] exp;

        tbl[0] = '{3, 6, 0, 3, 6};
        tbl[1] = '{14, 1, 0, 3, 6};
        tbl[2] = '{5, 7, 2, 2, 11};
        tbl[3] = '{9, 9, 0, 0, 3};
        tbl[4] = '{0, 15, 0, 15, 18};
        tbl[5] = '{15, 0, 1, 1, 6};
        tbl[6] = '{2, 1, 0, 15, 18};
        tbl[7] = '{7, 7, 3, 0, 6};

        bus.start = 0; bus.stop = 0; bus.auto_reload = 0;
        bus.start_val = '0; bus.end_val = '0; bus.presc = '0;
        rst_n = 1'b0;
        #1;
        check("reset outputs", obs(), 4'b0000);
        check("reset data_out", bus.data_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", obs(), 4'b0000);

        for (int i = 0; i < 8; i++) begin
            run_obs(tbl[i].sv, tbl[i].ev, tbl[i].p, 1'b0, n_en, dc);
            check($sformatf("vec%0d enables", i), n_en, tbl[i].n_en);
            check($sformatf("vec%0d done cycle", i), dc, tbl[i].done_cyc);
        end

        for (int i = 0; i < 10; i++) begin
            sv = $urandom_range(0, 15);
            ev = $urandom_range(0, 15);
            p  = $urandom_range(0, 3);
            run_obs(sv, ev, p, i[0], n_en, dc);
        end

        // Auto-reload: load / 2 enables / terminal / done, repeating, then stop mid-RUN.
        drive_start(0, 2, 0, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c <= 12) begin
                case ((c - 1) % 5)
                    0:       exp = 4'b1001;
                    1, 2:    exp = 4'b0101;
                    3:       exp = 4'b0001;
                    default: exp = 4'b0011;
                endcase
            end else begin
                exp = 4'b0000;
            end
            check($sformatf("reload c%0d", c), obs(), exp);
            bus.start = 1'b0;
            bus.stop  = (c == 12);
        end
        bus.auto_reload = 1'b0;

        // Asynchronous reset between clock edges mid-run.
        drive_start(1, 10, 1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("busy before async reset", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", obs(), 4'b0000);
        check("async reset data_out", bus.data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after async reset", obs(), 4'b0000);
        run_obs(4, 6, 0, 1'b0, n_en, dc);
        check("post-reset enables", n_en, 2);
        check("post-reset done cycle", dc, 5);

        // Stop beats start in IDLE: nothing captured.
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1; bus.start_val = 4'd11;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("stop beats start", obs(), 4'b0000);
        check("stop blocks capture", bus.data_out, 4);

        // Stop beats terminal detection: no done pulse.
        drive_start(9, 9, 0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check("stop-term load", obs(), 4'b1001);
        @(negedge clk);
        check("stop-term run", obs(), 4'b0001);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop beats terminal", obs(), 4'b0000);
        @(negedge clk);
        check("stays idle after stop", obs(), 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: counter data width; matches the downstream loadable counter.
REQ-002 Parameter PRESC_W, default 8: prescaler width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request to begin a count run; sampled in IDLE only.
REQ-006 stop  in  1  abort; highest priority after reset.
REQ-007 auto_reload  in  1  when 1 at start, run restarts from start_val after each completion.
REQ-008 start_val  in  WIDTH  value loaded into the counter at run start.
REQ-009 end_val  in  WIDTH  terminal count value.
REQ-010 presc  in  PRESC_W  tick period minus one; 0 gives a tick every RUN cycle.
REQ-011 count  in  WIDTH  current counter output, fed back from the counter.
REQ-012 load  out  1  drives counter load.
REQ-013 enable  out  1  drives counter enable.
REQ-014 data_out  out  WIDTH  drives counter data_in.
REQ-015 busy  out  1  high in LOAD, RUN and DONE.
REQ-016 done  out  1  one-cycle pulse per completed run.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-018 IDLE, start=1, stop=0: capture start_val, end_val, presc and auto_reload into shadow registers; next state LOAD.
REQ-019 LOAD: load=1 and data_out=start_val_q for exactly one cycle; next state RUN; prescaler cleared.
REQ-020 Tick generation in RUN:
- Prescaler increments every cycle from 0.
- tick=1 when prescaler==presc_q; prescaler then returns to 0.
REQ-021 RUN on tick:
- count!=end_val_q: enable=1 for that cycle only.
- count==end_val_q: enable=0; next state DONE.
REQ-022 DONE: done=1 for one cycle; next state LOAD if auto_reload_q=1, else IDLE.
REQ-023 load and enable SHALL never be high together; enable SHALL be 0 outside RUN.
REQ-024 data_out SHALL equal start_val_q in all states; load qualifies it.
REQ-025 Counting runs modulo 2^WIDTH; end_val < start_val counts through the wrap (14 to 15 to 0 to 1).
REQ-026 start_val==end_val: zero enable pulses; DONE follows the first tick.
REQ-027 Latency, first RUN cycle to terminal tick: ((end_val-start_val) mod 2^WIDTH)+1 ticks of (presc+1) cycles each.
REQ-028 stop=1 in any state: next state IDLE; load, enable and done are 0 from that edge; stop beats start and terminal detection in the same cycle.
REQ-029 start while busy SHALL be ignored; input changes during a run SHALL have no effect (shadow registers).

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, prescaler 0 and shadow registers 0.
REQ-031 During reset: load, enable, done and busy SHALL be 0 and data_out 0.
REQ-032 Reset deassertion mid-run SHALL resume from IDLE; no done pulse is issued for the aborted run.

Structure
REQ-033 Package count_ctrl_pkg SHALL hold:
- state enum (IDLE, LOAD, RUN, DONE);
- default WIDTH and PRESC_W constants.
REQ-034 The prescaler SHALL be a sub-module tick_gen (inputs clr, en, period; output tick); the FSM and output decode stay in count_ctrl.
REQ-035 Outputs SHALL be decoded from registered state, prescaler and count, with no other combinational paths from inputs.

Verification (start pulse at cycle 0 in each scenario)
REQ-036 start_val=3, end_val=6, presc=0 -> load at cycle 1; enable at cycles 2, 3, 4; done at cycle 6; IDLE at cycle 7.
REQ-037 start_val=14, end_val=1, presc=0 -> exactly 3 enable pulses (at counts 14, 15, 0); one done pulse.
REQ-038 start_val=5, end_val=7, presc=2 -> enable every 3rd RUN cycle (cycles 4 and 7); done at cycle 11.
REQ-039 start_val=end_val=9, presc=0 -> no enable; done at cycle 3.
REQ-040 auto_reload=1, start_val=0, end_val=2, presc=0 -> repeated load/2-enable/done cycles; stop asserted mid-RUN -> enable 0 next cycle, busy 0, no done.
REQ-041 rst_n pulsed low mid-RUN (asynchronously, between clock edges) -> load, enable, busy and done 0 immediately; a later start runs normally.
